axis_rr_arbiter_4to1: RTL and testbench
=======================================

AXIS_RR_ARBITER_4TO1 -- requirements
Module: axis_rr_arbiter_4to1

Interface
REQ-001 Parameter: BURST_LEN, default 4, maximum beats per grant when burst lock is compiled in; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: valid_0..valid_3  input  1 each  request lines, tapped from the same valids that drive the downstream 4:1 stream mux.
REQ-005 Port: ready  input  1  downstream ready, the same signal the mux receives.
REQ-006 Port: sel  output  2  registered mux select; drives the mux sel input.
REQ-007 Port: grant  output  4  registered one-hot of sel while busy; 4'b0000 when idle.
REQ-008 Port: busy  output  1  registered; high while a grant is held (state GRANT).

Function
REQ-009 Two states: IDLE and GRANT; state, sel, grant, busy, beat count and priority pointer are all flops.
REQ-010 Transfer: a beat completes in a cycle where busy=1, valid_<sel>=1 and ready=1.
REQ-011 Arbitration: the candidate is the first asserted valid scanning from index (ptr+1) mod 4 upward with wrap; ptr is the last granted index.
REQ-012 IDLE with any valid high: next cycle state=GRANT, sel=candidate, grant=onehot(candidate), busy=1, ptr=candidate, beat count=0; one-cycle arbitration latency.
REQ-013 IDLE with all valids low: state, sel and ptr hold.
REQ-014 GRANT: on each transfer the beat count increments by 1; the count saturates and never wraps.
REQ-015 GRANT release: occurs on a transfer that completes the allotted beats (REQ-023/REQ-024), or on any cycle where valid_<sel>=0.
REQ-016 Release with another arbitration candidate present (candidate computed from current valids and updated ptr=sel): re-grant in the same edge, staying in GRANT with the count at 0; zero bubble cycles.
REQ-017 The candidate set includes the releasing index itself; it wins only if no other valid is high (fairness).
REQ-018 Release with no candidate: next state is IDLE, busy=0 and grant=0, with sel holding its last value.
REQ-019 sel changes only on a clock edge and never mid-beat; with valid high and ready low, the grant holds indefinitely (no timeout).
REQ-020 Simultaneous requests on all four lines with continuous ready: grants rotate 0,1,2,3,0,... after reset.
REQ-021 The arbiter never inspects data; it is purely a handshake observer and select generator.

Reset
REQ-022 While rst_n=0 at a clock edge: state=IDLE, sel=2'b00, grant=4'b0000, busy=0, beat count=0, ptr=2'd3 (so index 0 has first priority); all valids are ignored during reset, and reset asserted mid-burst abandons the grant in that edge.

Configuration
REQ-023 With macro AXIS_ARB_BURST_LOCK_EN defined, the grant is held for up to BURST_LEN transfers and released on the transfer that makes the count equal BURST_LEN, or earlier per REQ-015.
REQ-024 Without AXIS_ARB_BURST_LOCK_EN, the grant is released after every single transfer; BURST_LEN and the beat counter are unused and may be optimised away.

Verification
REQ-025 Reset, then valid_2=1 only with ready=1 -> busy=1, sel=2, grant=4'b0100 one cycle after reset release.
REQ-026 All valids=1, ready=1, without the macro -> sel sequence 0,1,2,3,0 on consecutive cycles after the first grant, with busy continuously 1.
REQ-027 All valids=1, ready=1, macro on, BURST_LEN=4 -> sel=0 for 4 cycles, then 1 for 4 cycles, then 2, then 3; no idle cycles.
REQ-028 Granted valid_1=1 with ready=0 for 10 cycles, then ready=1 -> sel stays 1 throughout; the count increments only after ready rises.
REQ-029 Macro on, BURST_LEN=4, valid_0 drops after 2 transfers while valid_3=1 -> sel=3 on the next edge with the count reset to 0; valid_0 dropping with no other valid -> busy=0 and sel holds at 0.
REQ-030 rst_n=0 asserted mid-burst (sel=2, count=2) -> next edge gives busy=0, grant=0, sel=0; after release with all valids=1 the first grant is index 0.

Source files
------------

// File: rtl/axis_rr_arbiter_4to1.sv
// Round-robin 4:1 AXI-Stream arbiter: observes valid/ready handshakes and drives a registered mux select.
// Optional burst lock via AXIS_ARB_BURST_LOCK_EN: hold each grant for up to BURST_LEN transfers.
module axis_rr_arbiter_4to1 #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_0,
    input  logic       valid_1,
    input  logic       valid_2,
    input  logic       valid_3,
    input  logic       ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("axis_rr_arbiter_4to1: BURST_LEN must be in 1..255");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
`ifdef AXIS_ARB_BURST_LOCK_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
`endif

    logic [N_REQ-1:0]   valid_vec;
    logic [IDX_W:0]     pick_idle;
    logic [IDX_W:0]     pick_rel;
    logic               xfer;
    logic               last_beat;
    logic               rel;

    assign valid_vec = {valid_3, valid_2, valid_1, valid_0};

    // First asserted valid scanning upward from p+1 with wrap; returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] v, input logic [IDX_W-1:0] p);
        logic [IDX_W:0]   r;
        logic [IDX_W-1:0] idx;
        r = '0;
        for (int d = N_REQ; d >= 1; d--) begin
            idx = p + IDX_W'(d);
            if (v[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
`ifdef AXIS_ARB_BURST_LOCK_EN
        cnt_d     = cnt_q;
        cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        last_beat = (cnt_inc == CNT_W'(BURST_LEN));
`else
        last_beat = 1'b1;
`endif
        pick_idle = rr_pick(valid_vec, ptr_q);
        pick_rel  = rr_pick(valid_vec, sel_q);
        xfer      = valid_vec[sel_q] & ready;
        rel       = ~valid_vec[sel_q] | (xfer & last_beat);

        case (state_q)
            S_IDLE: begin
                if (pick_idle[IDX_W]) begin
                    state_d = S_GRANT;
                    sel_d   = pick_idle[IDX_W-1:0];
                    ptr_d   = pick_idle[IDX_W-1:0];
                    grant_d = onehot(pick_idle[IDX_W-1:0]);
                    busy_d  = 1'b1;
`ifdef AXIS_ARB_BURST_LOCK_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_GRANT: begin
                if (rel) begin
                    ptr_d = sel_q;
`ifdef AXIS_ARB_BURST_LOCK_EN
                    cnt_d = '0;
`endif
                    if (pick_rel[IDX_W]) begin
                        sel_d   = pick_rel[IDX_W-1:0];
                        ptr_d   = pick_rel[IDX_W-1:0];
                        grant_d = onehot(pick_rel[IDX_W-1:0]);
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end
`ifdef AXIS_ARB_BURST_LOCK_EN
                else if (xfer) begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset; ptr=3 gives index 0 first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(3);
            grant_q <= '0;
            busy_q  <= 1'b0;
`ifdef AXIS_ARB_BURST_LOCK_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
`ifdef AXIS_ARB_BURST_LOCK_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_axis_rr_arbiter_4to1.sv
// Self-checking bench for axis_rr_arbiter_4to1: directed scenarios plus random traffic vs a behavioural model.
module tb_axis_rr_arbiter_4to1;

    localparam int unsigned BURST = 4;
`ifdef AXIS_ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_0 = 1'b0, valid_1 = 1'b0, valid_2 = 1'b0, valid_3 = 1'b0;
    logic       ready = 1'b0;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state: owner index, busy flag, last-granted pointer, beats moved in this grant.
    int m_busy = 0;
    int m_sel = 0;
    int m_ptr = 3;
    int m_beats = 0;

    axis_rr_arbiter_4to1 #(.BURST_LEN(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
        .ready(ready), .sel(sel), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [3:0] v, input int p);
        for (int d = 1; d <= 4; d++) begin
            if (v[(p + d) % 4]) return (p + d) % 4;
        end
        return -1;
    endfunction

    // Model update on the same edge the DUT samples its inputs.
    always @(posedge clk) begin : model_upd
        logic [3:0] v;
        bit xfer;
        bit done;
        int w;
        v = {valid_3, valid_2, valid_1, valid_0};
        if (!rst_n) begin
            m_busy = 0; m_sel = 0; m_ptr = 3; m_beats = 0;
        end else if (m_busy == 0) begin
            w = winner(v, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_ptr = w; m_beats = 0;
            end
        end else begin
            xfer = v[m_sel] && ready;
            done = !v[m_sel] || (xfer && (!LOCK || (m_beats + 1 >= int'(BURST))));
            if (done) begin
                w = winner(v, m_sel);
                m_ptr = m_sel;
                m_beats = 0;
                if (w >= 0) begin
                    m_sel = w; m_ptr = w;
                end else begin
                    m_busy = 0;
                end
            end else if (xfer) begin
                m_beats++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", int'(busy), m_busy);
            check("cyc_sel", int'(sel), m_sel);
            check("cyc_grant", int'(grant), (m_busy != 0) ? (1 << m_sel) : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy, input logic rst);
        {valid_3, valid_2, valid_1, valid_0} = v;
        ready = rdy;
        rst_n = rst;
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic pin(input string name, input int dut_val, input int model_val, input int lit);
        check({name, "_dut"}, dut_val, lit);
        check({name, "_model"}, model_val, lit);
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b0);
        step(1);
    endtask

    initial begin
        logic [3:0] rv;
        int exp_sel;

        drive(4'b0000, 1'b0, 1'b0);
        step(3);
        cmp_en = 1'b1;
        pin("rst_busy", int'(busy), m_busy, 0);
        pin("rst_sel", int'(sel), m_sel, 0);
        pin("rst_grant", int'(grant), (m_busy != 0) ? (1 << m_sel) : 0, 0);

        // Single requester on line 2: one-cycle arbitration latency.
        drive(4'b0100, 1'b1, 1'b1);
        step(1);
        pin("v2_busy", int'(busy), m_busy, 1);
        pin("v2_sel", int'(sel), m_sel, 2);
        pin("v2_grant", int'(grant), (m_busy != 0) ? (1 << m_sel) : 0, 4);

        // All four requesting with continuous ready: rotation, per beat or per burst.
        do_reset();
        drive(4'b1111, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(1);
            exp_sel = LOCK ? ((k / int'(BURST)) % 4) : (k % 4);
            pin($sformatf("rot%0d_sel", k), int'(sel), m_sel, exp_sel);
            pin($sformatf("rot%0d_busy", k), int'(busy), m_busy, 1);
        end

        // Back-pressure: grant held while ready is low.
        do_reset();
        drive(4'b0010, 1'b0, 1'b1);
        step(1);
        for (int k = 0; k < 10; k++) begin
            step(1);
            pin($sformatf("bp%0d_sel", k), int'(sel), m_sel, 1);
        end
        drive(4'b0010, 1'b1, 1'b1);
        step(1);
        pin("bp_rel_sel", int'(sel), m_sel, 1);
        pin("bp_rel_busy", int'(busy), m_busy, 1);

        // Reset mid-burst abandons the grant; index 0 wins first afterwards.
        do_reset();
        drive(4'b0100, 1'b1, 1'b1);
        step(3);
        drive(4'b1111, 1'b1, 1'b0);
        step(1);
        pin("mid_rst_busy", int'(busy), m_busy, 0);
        pin("mid_rst_grant", int'(grant), (m_busy != 0) ? (1 << m_sel) : 0, 0);
        pin("mid_rst_sel", int'(sel), m_sel, 0);
        drive(4'b1111, 1'b1, 1'b1);
        step(1);
        pin("post_rst_sel", int'(sel), m_sel, 0);
        pin("post_rst_busy", int'(busy), m_busy, 1);

        // Owner drops valid early with another requester present.
        do_reset();
        drive(4'b0001, 1'b1, 1'b1);
        step(3);
        drive(4'b1000, 1'b1, 1'b1);
        step(1);
        pin("drop_sel", int'(sel), m_sel, 3);
        pin("drop_busy", int'(busy), m_busy, 1);

        // Owner drops valid with nobody else: idle, sel holds.
        do_reset();
        drive(4'b0001, 1'b1, 1'b1);
        step(3);
        drive(4'b0000, 1'b1, 1'b1);
        step(1);
        pin("idle_busy", int'(busy), m_busy, 0);
        pin("idle_sel", int'(sel), m_sel, 0);
        pin("idle_grant", int'(grant), (m_busy != 0) ? (1 << m_sel) : 0, 0);

        // Random traffic with occasional resets; checked every cycle by the compare process.
        rv = 4'b0000;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
            drive(rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
            step(1);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
